sb_rx_packet_engine: RTL and testbench
======================================

# sb_rx_packet_engine

Parametrised sideband receive engine that succeeds the single-message RX FSM. It sits between the sideband deserializer and the LTSM/adapter consumers. It detects clock-pattern lock with a configurable match count, then decodes header and multi-word payload messages with header/data parity checking. Decoded packets land in a first-word-fall-through queue, so multiple messages can be held while the consumer is busy.

## Interface
- DATA_WORDS, 2: 64-bit payload words carried by a message-with-data (1..8).
- PATTERN_COUNT, 2: consecutive pattern words required to declare lock (1..15).
- FIFO_DEPTH, 4: decoded-packet queue depth, power of 2 (2..16).
- i_clk  in  1  sideband clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_de_ser_done  in  1  one-cycle strobe: i_deser_data holds a new word.
- i_deser_data  in  64  deserialized word.
- i_reset_req  in  1  LTSM in RESET; level, abort and return to hunting.
- i_pop  in  1  consumer accepts head packet.
- o_de_ser_done_sampled  out  1  i_de_ser_done delayed one cycle (ack).
- o_pattern_locked  out  1  lock achieved; level.
- o_pattern_samp_done  out  1  one-cycle pulse on lock.
- o_pkt_valid  out  1  queue not empty.
- o_pkt_header  out  64  head packet header.
- o_pkt_data  out  64*DATA_WORDS  head payload, word 0 in LSBs; zero for no-data packets.
- o_pkt_has_data  out  1  head packet carried payload.
- o_pkt_adapter  out  1  head packet dstid[0]=1 (adapter-bound).
- o_rsp_delivered  out  1  pulse: pushed packet is a response (header[17:14]=4'hA).
- o_parity_error  out  1  pulse: header or data parity failure.
- o_overflow  out  1  pulse: packet dropped, queue full.

## Operation
- Pattern word: i_deser_data == 64'hAAAA_AAAA_AAAA_AAAA.
- Header fields: opcode [4:0], subcode [17:14], msgcode [21:18], dstid [58:56], cp [62], dp [63].
- Header parity is good when the XOR of [62:0] is 0. Data parity is good when the XOR of all payload bits XOR dp is 0.
- Message-with-data: opcode == 5'b11011. All other opcodes are header-only.
- States:
  - IDLE: the first word strobe moves to HUNT. If that word is a pattern, cnt=1; otherwise cnt=0.
  - HUNT: a pattern word increments cnt; a non-pattern word clears cnt. When cnt reaches PATTERN_COUNT: go to LOCKED, pulse o_pattern_samp_done, set o_pattern_locked.
  - LOCKED: a pattern word is ignored. A bad-parity header pulses o_parity_error, is discarded, and the state stays LOCKED. A good header with data is latched and the state goes to DATA with wcnt=0. A good header-only message is pushed.
  - DATA: each strobe stores a word at index wcnt. Pattern words are treated as data. After word DATA_WORDS-1, check parity: good → push; bad → pulse o_parity_error and discard. Return to LOCKED.
- Push behaviour:
  - If the queue is full and i_pop is not asserted that cycle, the packet is dropped and o_overflow pulses.
  - Push and pop in the same cycle on a full queue both succeed.
  - o_rsp_delivered pulses only on a successful push.
- i_pop while the queue is empty is ignored.
- i_reset_req high, in any state: next state is IDLE; cnt, wcnt, o_pattern_locked and any partial packet are cleared; the queue is flushed. This has priority over a simultaneous strobe.

## Timing
- Reset values: all outputs 0; state IDLE; queue empty.
- o_de_ser_done_sampled: exactly 1 cycle after i_de_ser_done.
- Strobes are sampled on the rising edge. A strobe at edge E may be followed by another strobe at edge E+1; back-to-back strobes are accepted with no bubble.
- Header-only packet: header strobe at edge E; checked and pushed at edge E+1; o_pkt_valid high after E+1 if the queue was empty.
- Data packet: last payload strobe at edge E; push or parity error at edge E+1.
- Pulse timing: o_pattern_samp_done, o_parity_error, o_overflow and o_rsp_delivered are high for exactly the one cycle following the deciding edge.
- o_pattern_locked rises in the same cycle as o_pattern_samp_done.
- Pop: o_pkt_* update the cycle after the i_pop edge. Throughput is one push and one pop per cycle.

## Test plan
- Lock: send PATTERN_COUNT=2 pattern words → o_pattern_samp_done pulses once, o_pattern_locked=1. Send pattern, non-pattern, pattern → no lock until two consecutive patterns.
- Header-only: after lock, send a good header with opcode 5'b10010 and subcode 4'hA → o_pkt_valid=1, o_pkt_header matches, o_pkt_has_data=0, o_rsp_delivered pulses. Assert i_pop → o_pkt_valid=0.
- Data message: header opcode 5'b11011 plus 2 words 64'h1 and 64'h2 with correct dp → o_pkt_data={64'h2,64'h1}, o_pkt_has_data=1. Repeat with dp flipped → o_parity_error pulses and nothing is queued.
- Header parity: a header with a single bit flipped → o_parity_error pulses, state stays LOCKED, and the next good header is accepted.
- Overflow: push 5 header-only packets with no pops (FIFO_DEPTH=4) → o_overflow pulses on the 5th and the queue holds packets 1-4 in order. Push with a same-cycle pop when full → no overflow.
- Reset request: assert i_reset_req mid-DATA with 2 packets queued → o_pattern_locked=0, o_pkt_valid=0, a new lock is required. Apply i_rst_n low mid-stream → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/sb_rx_packet_engine.sv
// sb_rx_packet_engine
//   Sideband receive engine. Hunts for clock-pattern lock, then decodes
//   header-only and header+payload messages with parity checks and queues
//   good packets in a first-word-fall-through FIFO for the consumer.
//
// Ports
//   i_clk, i_rst_n          sideband clock, async active-low reset
//   i_de_ser_done           strobe: i_deser_data holds a new 64-bit word
//   i_deser_data            deserialized word
//   i_reset_req             level: abort, flush queue, return to hunting
//   i_pop                   consumer accepts head packet
//   o_de_ser_done_sampled   strobe delayed one cycle (ack)
//   o_pattern_locked        lock level
//   o_pattern_samp_done     one-cycle pulse when lock is declared
//   o_pkt_valid             queue not empty
//   o_pkt_header/_data      head packet header / payload (word 0 in LSBs)
//   o_pkt_has_data          head packet carried payload
//   o_pkt_adapter           head packet dstid[0]
//   o_rsp_delivered         pulse: pushed packet is a response (subcode 4'hA)
//   o_parity_error          pulse: header or data parity failure
//   o_overflow              pulse: packet dropped, queue full
//
// state  | meaning
// IDLE   | nothing seen since reset / reset request
// HUNT   | counting consecutive pattern words
// LOCKED | decoding headers, pattern words ignored
// DATA   | collecting payload words for a latched header
module sb_rx_packet_engine #(
    parameter int DATA_WORDS    = 2,
    parameter int PATTERN_COUNT = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_de_ser_done,
    input  logic [63:0]              i_deser_data,
    input  logic                     i_reset_req,
    input  logic                     i_pop,
    output logic                     o_de_ser_done_sampled,
    output logic                     o_pattern_locked,
    output logic                     o_pattern_samp_done,
    output logic                     o_pkt_valid,
    output logic [63:0]              o_pkt_header,
    output logic [64*DATA_WORDS-1:0] o_pkt_data,
    output logic                     o_pkt_has_data,
    output logic                     o_pkt_adapter,
    output logic                     o_rsp_delivered,
    output logic                     o_parity_error,
    output logic                     o_overflow
);

    localparam logic [63:0] PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam int PW = 64 * DATA_WORDS;
    localparam int EW = 64 + PW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    PCNT    = 4'(PATTERN_COUNT);
    localparam logic [2:0]    LAST_W  = 3'(DATA_WORDS - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_DATA   = 2'd3;

    logic [1:0]    state, state_d;
    logic [3:0]    cnt, cnt_d, cnt_inc;
    logic [2:0]    wcnt, wcnt_d;
    logic [63:0]   hdr_q, hdr_d;
    logic [PW-1:0] payload_q, payload_d, payload_nxt;
    logic          strb_q;
    logic [63:0]   word_q;

    logic          is_pat, hdr_good, data_good, is_data_op;
    logic          lock_pulse, perr, push_req;
    logic [EW-1:0] push_entry;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop_ok, push_ok;
    logic [EW-1:0] head;

    // Words are staged one cycle so that decode happens on the edge after
    // the strobe; the deserializer may strobe every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de_ser_done_sampled <= 1'b0;
            strb_q                <= 1'b0;
            word_q                <= '0;
        end else begin
            o_de_ser_done_sampled <= i_de_ser_done;
            strb_q                <= i_de_ser_done && !i_reset_req;
            if (i_de_ser_done) word_q <= i_deser_data;
        end
    end

    assign is_pat     = (word_q == PATTERN);
    assign hdr_good   = ~(^word_q[62:0]);
    assign is_data_op = (word_q[4:0] == 5'b11011);
    assign cnt_inc    = cnt + 4'd1;

    always_comb begin
        payload_nxt = payload_q;
        payload_nxt[64*int'(wcnt) +: 64] = word_q;
    end

    assign data_good = ~(^payload_nxt ^ hdr_q[63]);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        wcnt_d     = wcnt;
        hdr_d      = hdr_q;
        payload_d  = payload_q;
        lock_pulse = 1'b0;
        perr       = 1'b0;
        push_req   = 1'b0;
        push_entry = '0;
        if (strb_q) begin
            case (state)
                ST_IDLE, ST_HUNT: begin
                    state_d = ST_HUNT;
                    cnt_d   = is_pat ? cnt_inc : 4'd0;
                    if (is_pat && cnt_inc == PCNT) begin
                        state_d    = ST_LOCKED;
                        cnt_d      = 4'd0;
                        lock_pulse = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!is_pat) begin
                        if (!hdr_good) begin
                            perr = 1'b1;
                        end else if (is_data_op) begin
                            hdr_d   = word_q;
                            wcnt_d  = 3'd0;
                            state_d = ST_DATA;
                        end else begin
                            push_req   = 1'b1;
                            push_entry = {word_q, {PW{1'b0}}, 1'b0};
                        end
                    end
                end
                default: begin
                    payload_d = payload_nxt;
                    wcnt_d    = wcnt + 3'd1;
                    if (wcnt == LAST_W) begin
                        state_d = ST_LOCKED;
                        wcnt_d  = 3'd0;
                        if (data_good) begin
                            push_req   = 1'b1;
                            push_entry = {hdr_q, payload_nxt, 1'b1};
                        end else begin
                            perr = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // A pop on a full queue frees the slot the same-cycle push needs.
    assign pop_ok  = i_pop && (count != '0);
    assign push_ok = push_req && ((count != DEPTH_C) || pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            wcnt                <= '0;
            hdr_q               <= '0;
            payload_q           <= '0;
            o_pattern_locked    <= 1'b0;
            o_pattern_samp_done <= 1'b0;
            o_parity_error      <= 1'b0;
            o_overflow          <= 1'b0;
            o_rsp_delivered     <= 1'b0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
        end else if (i_reset_req) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            wcnt                <= '0;
            hdr_q               <= '0;
            payload_q           <= '0;
            o_pattern_locked    <= 1'b0;
            o_pattern_samp_done <= 1'b0;
            o_parity_error      <= 1'b0;
            o_overflow          <= 1'b0;
            o_rsp_delivered     <= 1'b0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
        end else begin
            state               <= state_d;
            cnt                 <= cnt_d;
            wcnt                <= wcnt_d;
            hdr_q               <= hdr_d;
            payload_q           <= payload_d;
            if (lock_pulse) o_pattern_locked <= 1'b1;
            o_pattern_samp_done <= lock_pulse;
            o_parity_error      <= perr;
            o_overflow          <= push_req && !push_ok;
            o_rsp_delivered     <= push_ok && (push_entry[EW-47 -: 4] == 4'hA);
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_reset_req) mem[wr_ptr] <= push_entry;
    end

    assign head           = mem[rd_ptr];
    assign o_pkt_valid    = (count != '0);
    assign o_pkt_header   = o_pkt_valid ? head[EW-1 -: 64] : 64'd0;
    assign o_pkt_data     = o_pkt_valid ? head[PW:1] : {PW{1'b0}};
    assign o_pkt_has_data = o_pkt_valid && head[0];
    assign o_pkt_adapter  = o_pkt_header[56];

endmodule

// File: tb/tb_sb_rx_packet_engine.sv
module tb_sb_rx_packet_engine;

    localparam int DW = 2;
    localparam int PC = 2;
    localparam int FD = 4;
    localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

    logic              i_clk, i_rst_n, i_de_ser_done, i_reset_req, i_pop;
    logic [63:0]       i_deser_data;
    logic              o_de_ser_done_sampled, o_pattern_locked, o_pattern_samp_done;
    logic              o_pkt_valid, o_pkt_has_data, o_pkt_adapter;
    logic [63:0]       o_pkt_header;
    logic [64*DW-1:0]  o_pkt_data;
    logic              o_rsp_delivered, o_parity_error, o_overflow;

    sb_rx_packet_engine #(.DATA_WORDS(DW), .PATTERN_COUNT(PC), .FIFO_DEPTH(FD)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_de_ser_done(i_de_ser_done),
        .i_deser_data(i_deser_data), .i_reset_req(i_reset_req), .i_pop(i_pop),
        .o_de_ser_done_sampled(o_de_ser_done_sampled), .o_pattern_locked(o_pattern_locked),
        .o_pattern_samp_done(o_pattern_samp_done), .o_pkt_valid(o_pkt_valid),
        .o_pkt_header(o_pkt_header), .o_pkt_data(o_pkt_data), .o_pkt_has_data(o_pkt_has_data),
        .o_pkt_adapter(o_pkt_adapter), .o_rsp_delivered(o_rsp_delivered),
        .o_parity_error(o_parity_error), .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0]      hdr;
        logic [64*DW-1:0] data;
        logic             has;
    } pkt_t;

    pkt_t        m_q[$];
    logic [63:0] m_words[$];
    logic [63:0] m_hdr;
    bit          m_locked, m_in_data, m_pop_pend;
    int          m_run;
    int          e_lock, e_perr, e_ovf, e_rsp;
    int          n_lock, n_perr, n_ovf, n_rsp;
    int          n_checks, n_errors;

    always @(negedge i_clk) begin
        if (o_pattern_samp_done) n_lock++;
        if (o_parity_error)      n_perr++;
        if (o_overflow)          n_ovf++;
        if (o_rsp_delivered)     n_rsp++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_push(input pkt_t p);
        if (m_pop_pend) begin
            if (m_q.size() > 0) m_q.delete(0);
            m_pop_pend = 0;
        end
        if (m_q.size() >= FD) e_ovf++;
        else begin
            m_q.push_back(p);
            if (p.hdr[17:14] == 4'hA) e_rsp++;
        end
    endtask

    task automatic m_word(input logic [63:0] w);
        pkt_t p;
        if (!m_locked) begin
            m_run = (w == PAT) ? m_run + 1 : 0;
            if (m_run == PC) begin
                m_locked = 1;
                m_run = 0;
                e_lock++;
            end
        end else if (m_in_data) begin
            m_words.push_back(w);
            if (m_words.size() == DW) begin
                p.hdr = m_hdr;
                p.has = 1'b1;
                for (int i = 0; i < DW; i++) p.data[64*i +: 64] = m_words[i];
                if ((^p.data) == m_hdr[63]) m_push(p);
                else e_perr++;
                m_in_data = 0;
            end
        end else if (w == PAT) begin
        end else if (^w[62:0]) begin
            e_perr++;
        end else if (w[4:0] == 5'b11011) begin
            m_hdr = w;
            m_in_data = 1;
            m_words.delete();
        end else begin
            p.hdr = w;
            p.data = '0;
            p.has = 1'b0;
            m_push(p);
        end
    endtask

    task automatic m_clear();
        m_locked = 0;
        m_run = 0;
        m_in_data = 0;
        m_words.delete();
        m_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drive one word; optionally pop on the following edge (the edge on
    // which this word's push, if any, lands).
    task automatic send_word(input logic [63:0] w, input bit pop_next);
        i_de_ser_done = 1'b1;
        i_deser_data  = w;
        @(posedge i_clk);
        #1;
        i_de_ser_done = 1'b0;
        m_pop_pend = pop_next;
        m_word(w);
        if (pop_next) begin
            i_pop = 1'b1;
            @(posedge i_clk);
            #1;
            i_pop = 1'b0;
            if (m_pop_pend) begin
                if (m_q.size() > 0) m_q.delete(0);
                m_pop_pend = 0;
            end
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [3:0] sub,
                                           input logic dp);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[4:0]   = op;
        h[17:14] = sub;
        h[63]    = dp;
        h[62]    = ^h[61:0];
        return h;
    endfunction

    function automatic logic [4:0] rand_hdr_op();
        logic [4:0] op;
        do op = 5'($urandom_range(0, 31)); while (op == 5'b11011);
        return op;
    endfunction

    task automatic send_pkt(input bit has, input bit bad_hdr, input bit bad_dp,
                            input bit allow_pop);
        logic [63:0]      h;
        logic [64*DW-1:0] pl;
        logic [3:0]       sub;
        int               idx;
        sub = ($urandom_range(0, 3) == 0) ? 4'hA : 4'($urandom);
        for (int i = 0; i < DW; i++)
            pl[64*i +: 64] = ($urandom_range(0, 15) == 0) ? PAT : {$urandom, $urandom};
        h = mk_hdr(has ? 5'b11011 : rand_hdr_op(), sub, (^pl) ^ bad_dp);
        if (bad_hdr) begin
            idx = $urandom_range(0, 62);
            h[idx] = ~h[idx];
        end
        send_word(h, allow_pop && ($urandom_range(0, 2) == 0));
        if (has && !bad_hdr)
            for (int i = 0; i < DW; i++)
                send_word(pl[64*i +: 64], allow_pop && ($urandom_range(0, 2) == 0));
    endtask

    task automatic check_counts(input string tag);
        idle(2);
        chk({tag, "_lock_pulses"}, 512'(n_lock), 512'(e_lock));
        chk({tag, "_perr_pulses"}, 512'(n_perr), 512'(e_perr));
        chk({tag, "_ovf_pulses"},  512'(n_ovf),  512'(e_ovf));
        chk({tag, "_rsp_pulses"},  512'(n_rsp),  512'(e_rsp));
        chk({tag, "_locked"},      512'(o_pattern_locked), 512'(m_locked));
    endtask

    task automatic drain(input string tag);
        pkt_t p;
        idle(2);
        while (m_q.size() > 0) begin
            p = m_q[0];
            chk({tag, "_valid"},   512'(o_pkt_valid), 512'(1'b1));
            chk({tag, "_header"},  512'(o_pkt_header), 512'(p.hdr));
            chk({tag, "_data"},    512'(o_pkt_data), 512'(p.data));
            chk({tag, "_has_data"}, 512'(o_pkt_has_data), 512'(p.has));
            chk({tag, "_adapter"}, 512'(o_pkt_adapter), 512'(p.hdr[56]));
            i_pop = 1'b1;
            @(posedge i_clk);
            #1;
            i_pop = 1'b0;
            m_q.delete(0);
        end
        chk({tag, "_empty"}, 512'(o_pkt_valid), 512'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},     512'(o_de_ser_done_sampled), 512'(0));
        chk({tag, "_locked"},  512'(o_pattern_locked), 512'(0));
        chk({tag, "_sampdone"}, 512'(o_pattern_samp_done), 512'(0));
        chk({tag, "_valid"},   512'(o_pkt_valid), 512'(0));
        chk({tag, "_header"},  512'(o_pkt_header), 512'(0));
        chk({tag, "_data"},    512'(o_pkt_data), 512'(0));
        chk({tag, "_has"},     512'(o_pkt_has_data), 512'(0));
        chk({tag, "_adapter"}, 512'(o_pkt_adapter), 512'(0));
        chk({tag, "_rsp"},     512'(o_rsp_delivered), 512'(0));
        chk({tag, "_perr"},    512'(o_parity_error), 512'(0));
        chk({tag, "_ovf"},     512'(o_overflow), 512'(0));
    endtask

    initial begin
        logic [63:0] h;
        n_checks = 0; n_errors = 0;
        e_lock = 0; e_perr = 0; e_ovf = 0; e_rsp = 0;
        n_lock = 0; n_perr = 0; n_ovf = 0; n_rsp = 0;
        m_pop_pend = 0;
        m_clear();
        i_rst_n = 1'b0; i_de_ser_done = 1'b0; i_deser_data = '0;
        i_reset_req = 1'b0; i_pop = 1'b0;
        #12;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        idle(2);

        // Lock: only consecutive patterns count
        send_word(PAT, 0);
        chk("ack_high", 512'(o_de_ser_done_sampled), 512'(1));
        idle(1);
        chk("ack_low", 512'(o_de_ser_done_sampled), 512'(0));
        send_word(64'h1234, 0);
        send_word(PAT, 0);
        idle(2);
        chk("no_lock_yet", 512'(o_pattern_locked), 512'(0));
        send_word(PAT, 0);
        idle(1);
        chk("lock_pulse", 512'(o_pattern_samp_done), 512'(1));
        chk("lock_level", 512'(o_pattern_locked), 512'(1));
        idle(1);
        chk("lock_pulse_end", 512'(o_pattern_samp_done), 512'(0));
        check_counts("lock");

        // Header-only response
        h = mk_hdr(5'b10010, 4'hA, 1'($urandom));
        send_word(h, 0);
        idle(1);
        chk("hdr_valid_timing", 512'(o_pkt_valid), 512'(1));
        chk("hdr_rsp_pulse", 512'(o_rsp_delivered), 512'(1));
        drain("hdr");
        check_counts("hdr");

        // Data message, good then bad data parity
        send_word(mk_hdr(5'b11011, 4'h3, 1'b0), 0);
        send_word(64'h1, 0);
        send_word(64'h2, 0);
        idle(2);
        chk("data_payload", 512'(o_pkt_data), 512'({64'h2, 64'h1}));
        chk("data_has", 512'(o_pkt_has_data), 512'(1));
        drain("data");
        send_word(mk_hdr(5'b11011, 4'h3, 1'b1), 0);
        send_word(64'h1, 0);
        send_word(64'h2, 0);
        idle(1);
        chk("dp_perr_pulse", 512'(o_parity_error), 512'(1));
        idle(1);
        chk("dp_nothing_queued", 512'(o_pkt_valid), 512'(0));
        check_counts("dp");

        // Header parity
        h = mk_hdr(5'b10010, 4'h1, 1'b0);
        h[5] = ~h[5];
        send_word(h, 0);
        idle(1);
        chk("hp_perr_pulse", 512'(o_parity_error), 512'(1));
        send_word(mk_hdr(5'b00001, 4'h2, 1'b0), 0);
        drain("hp");
        check_counts("hp");

        // Overflow on 5th back-to-back push, then full push with same-cycle pop
        for (int i = 0; i < 5; i++) send_word(mk_hdr(rand_hdr_op(), 4'(i), 1'b0), 0);
        idle(1);
        chk("ovf_pulse", 512'(o_overflow), 512'(1));
        drain("ovf");
        check_counts("ovf");
        for (int i = 0; i < 4; i++) send_word(mk_hdr(rand_hdr_op(), 4'hA, 1'b0), 0);
        idle(2);
        send_word(mk_hdr(rand_hdr_op(), 4'h5, 1'b0), 1);
        check_counts("fullpop");
        drain("fullpop");

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) send_word(PAT, 0);
            send_pkt(1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (n % 25 == 24) check_counts("rand");
        end
        drain("rand");
        check_counts("rand_end");

        // Reset request mid-DATA with two packets queued
        send_word(mk_hdr(5'b00010, 4'h1, 1'b0), 0);
        send_word(mk_hdr(5'b00011, 4'h2, 1'b0), 0);
        send_word(mk_hdr(5'b11011, 4'h3, 1'b0), 0);
        send_word(64'h55, 0);
        i_reset_req = 1'b1;
        idle(1);
        i_reset_req = 1'b0;
        m_clear();
        idle(1);
        chk("rreq_locked", 512'(o_pattern_locked), 512'(0));
        chk("rreq_valid", 512'(o_pkt_valid), 512'(0));
        send_word(mk_hdr(5'b00010, 4'h1, 1'b0), 0);
        idle(2);
        chk("rreq_needs_lock", 512'(o_pkt_valid), 512'(0));
        send_word(PAT, 0);
        send_word(PAT, 0);
        send_word(mk_hdr(5'b00100, 4'hA, 1'b0), 0);
        drain("rreq");
        check_counts("rreq");

        // Asynchronous reset mid-stream
        send_word(mk_hdr(5'b00101, 4'h7, 1'b0), 0);
        idle(2);
        chk("arst_pre_valid", 512'(o_pkt_valid), 512'(1));
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        #3;
        i_rst_n = 1'b1;
        m_clear();
        idle(1);
        send_word(PAT, 0);
        send_word(PAT, 0);
        send_word(mk_hdr(5'b00110, 4'h9, 1'b0), 0);
        drain("arst_recover");
        check_counts("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
